// File: rtl/issue_queue_ooo.sv
// issue_queue_ooo
// Collapsing, age-ordered issue queue with a register scoreboard and branch-tag
// flush. Entry 0 is the oldest. Each cycle up to ISSUE_W hazard-free entries are
// picked oldest first and registered onto the issue lanes. Writeback clears
// scoreboard bits.
//
// Optional feature macro: ISSUE_QUEUE_PERF_CNT_EN (adds saturating stall/issue counters).
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   in_vld/in_op/.../in_bid  DISPATCH_W dispatch lanes (lane i = slice i)
//   in_rdy                   at least DISPATCH_W free entries (from registered count)
//   wb_vld/wb_des            WB_W writeback ports, clear scoreboard bits
//   flush_en/flush_id        kill every queued/dispatching/selected entry with this tag
//   iq_out_vld/iq_out_*      ISSUE_W registered issue lanes
//   entry_full/entry_empty   registered count == DEPTH / count == 0
//   perf_stall_cnt           (macro only) cycles with dispatch refused
//   perf_issue_cnt           (macro only) instructions issued
module issue_queue_ooo #(
  parameter int DEPTH      = 16,
  parameter int DISPATCH_W = 2,
  parameter int ISSUE_W    = 4,
  parameter int WB_W       = 4,
  parameter int NREG       = 16,
  parameter int BID_W      = 3,
  parameter int OPW        = 4,
  parameter int IME_W      = 5,
  parameter int REG_W      = $clog2(NREG)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DISPATCH_W-1:0]       in_vld,
  input  logic [DISPATCH_W*OPW-1:0]   in_op,
  input  logic [DISPATCH_W*REG_W-1:0] in_des,
  input  logic [DISPATCH_W*REG_W-1:0] in_s1,
  input  logic [DISPATCH_W*REG_W-1:0] in_s2,
  input  logic [DISPATCH_W*IME_W-1:0] in_ime,
  input  logic [DISPATCH_W*BID_W-1:0] in_bid,
  output logic                        in_rdy,
  input  logic [WB_W-1:0]             wb_vld,
  input  logic [WB_W*REG_W-1:0]       wb_des,
  input  logic                        flush_en,
  input  logic [BID_W-1:0]            flush_id,
  output logic [ISSUE_W-1:0]          iq_out_vld,
  output logic [ISSUE_W*OPW-1:0]      iq_out_op,
  output logic [ISSUE_W*REG_W-1:0]    iq_out_des,
  output logic [ISSUE_W*REG_W-1:0]    iq_out_s1,
  output logic [ISSUE_W*REG_W-1:0]    iq_out_s2,
  output logic [ISSUE_W*IME_W-1:0]    iq_out_ime,
  output logic [ISSUE_W*BID_W-1:0]    iq_out_bid,
  output logic                        entry_full,
  output logic                        entry_empty
`ifdef ISSUE_QUEUE_PERF_CNT_EN
  ,
  output logic [31:0]                 perf_stall_cnt,
  output logic [31:0]                 perf_issue_cnt
`endif
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int LANE_W = (ISSUE_W > 1) ? $clog2(ISSUE_W) : 1;
  localparam int LN_W   = LANE_W + 1;

  logic [OPW-1:0]   q_op  [DEPTH];
  logic [REG_W-1:0] q_des [DEPTH];
  logic [REG_W-1:0] q_s1  [DEPTH];
  logic [REG_W-1:0] q_s2  [DEPTH];
  logic [IME_W-1:0] q_ime [DEPTH];
  logic [BID_W-1:0] q_bid [DEPTH];
  logic [CNT_W-1:0] count;
  logic [NREG-1:0]  busy;

  logic [OPW-1:0]   n_op  [DEPTH];
  logic [REG_W-1:0] n_des [DEPTH];
  logic [REG_W-1:0] n_s1  [DEPTH];
  logic [REG_W-1:0] n_s2  [DEPTH];
  logic [IME_W-1:0] n_ime [DEPTH];
  logic [BID_W-1:0] n_bid [DEPTH];
  logic [CNT_W-1:0] n_count;
  logic [NREG-1:0]  busy_nx;

  logic [DEPTH-1:0] valid, ready, sel, kill;
  logic [IDX_W-1:0] sel_idx [ISSUE_W];
  logic [ISSUE_W-1:0] lane_used, lane_fire;

  // Reg 0 is hard-wired clear, so it never reports busy.
  function automatic logic reg_busy(input logic [REG_W-1:0] r, input logic [NREG-1:0] b);
    return (r != '0) && b[r];
  endfunction

  // in_rdy deliberately looks only at the registered count, never at this cycle's issue.
  assign in_rdy = (CNT_W'(DEPTH) - count) >= CNT_W'(DISPATCH_W);

  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      valid[e] = CNT_W'(e) < count;
      kill[e]  = valid[e] && flush_en && (q_bid[e] == flush_id);
      ready[e] = valid[e] && !reg_busy(q_s1[e], busy) && !reg_busy(q_s2[e], busy)
                 && !reg_busy(q_des[e], busy);
      // Any older entry still queued orders against this one (RAW, WAW, WAR); reg 0 never conflicts.
      for (int o = 0; o < e; o++) begin
        if (q_s1[e] != '0 && q_des[o] == q_s1[e]) ready[e] = 1'b0;
        if (q_s2[e] != '0 && q_des[o] == q_s2[e]) ready[e] = 1'b0;
        if (q_des[e] != '0 && (q_des[o] == q_des[e] || q_s1[o] == q_des[e] ||
                               q_s2[o] == q_des[e])) ready[e] = 1'b0;
      end
    end
  end

  always_comb begin : select_blk
    logic [LN_W-1:0] n;
    n         = '0;
    sel       = '0;
    lane_used = '0;
    for (int k = 0; k < ISSUE_W; k++) sel_idx[k] = '0;
    for (int e = 0; e < DEPTH; e++) begin
      if (ready[e] && n < LN_W'(ISSUE_W)) begin
        sel[e]                    = 1'b1;
        sel_idx[n[LANE_W-1:0]]    = IDX_W'(e);
        lane_used[n[LANE_W-1:0]]  = 1'b1;
        n                         = n + LN_W'(1);
      end
    end
    for (int k = 0; k < ISSUE_W; k++)
      lane_fire[k] = lane_used[k] && !(flush_en && q_bid[sel_idx[k]] == flush_id);
  end

  // Survivors slide down in age order, then accepted dispatch lanes append behind them.
  always_comb begin : compact_blk
    logic [CNT_W-1:0] pos;
    n_op  = q_op;
    n_des = q_des;
    n_s1  = q_s1;
    n_s2  = q_s2;
    n_ime = q_ime;
    n_bid = q_bid;
    pos   = '0;
    for (int e = 0; e < DEPTH; e++) begin
      if (valid[e] && !sel[e] && !kill[e]) begin
        n_op[pos[IDX_W-1:0]]  = q_op[e];
        n_des[pos[IDX_W-1:0]] = q_des[e];
        n_s1[pos[IDX_W-1:0]]  = q_s1[e];
        n_s2[pos[IDX_W-1:0]]  = q_s2[e];
        n_ime[pos[IDX_W-1:0]] = q_ime[e];
        n_bid[pos[IDX_W-1:0]] = q_bid[e];
        pos = pos + CNT_W'(1);
      end
    end
    for (int i = 0; i < DISPATCH_W; i++) begin
      if (in_rdy && in_vld[i] && !(flush_en && in_bid[i*BID_W +: BID_W] == flush_id)) begin
        n_op[pos[IDX_W-1:0]]  = in_op[i*OPW +: OPW];
        n_des[pos[IDX_W-1:0]] = in_des[i*REG_W +: REG_W];
        n_s1[pos[IDX_W-1:0]]  = in_s1[i*REG_W +: REG_W];
        n_s2[pos[IDX_W-1:0]]  = in_s2[i*REG_W +: REG_W];
        n_ime[pos[IDX_W-1:0]] = in_ime[i*IME_W +: IME_W];
        n_bid[pos[IDX_W-1:0]] = in_bid[i*BID_W +: BID_W];
        pos = pos + CNT_W'(1);
      end
    end
    n_count = pos;
  end

  // Clears first, then sets, so an issue to the same register wins over writeback.
  always_comb begin
    busy_nx = busy;
    for (int j = 0; j < WB_W; j++)
      if (wb_vld[j]) busy_nx[wb_des[j*REG_W +: REG_W]] = 1'b0;
    for (int k = 0; k < ISSUE_W; k++)
      if (lane_fire[k] && q_des[sel_idx[k]] != '0) busy_nx[q_des[sel_idx[k]]] = 1'b1;
    busy_nx[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count       <= '0;
      busy        <= '0;
      entry_full  <= 1'b0;
      entry_empty <= 1'b1;
      for (int e = 0; e < DEPTH; e++) begin
        q_op[e]  <= '0;
        q_des[e] <= '0;
        q_s1[e]  <= '0;
        q_s2[e]  <= '0;
        q_ime[e] <= '0;
        q_bid[e] <= '0;
      end
      iq_out_vld <= '0;
      iq_out_op  <= '0;
      iq_out_des <= '0;
      iq_out_s1  <= '0;
      iq_out_s2  <= '0;
      iq_out_ime <= '0;
      iq_out_bid <= '0;
    end else begin
      count       <= n_count;
      busy        <= busy_nx;
      entry_full  <= (n_count == CNT_W'(DEPTH));
      entry_empty <= (n_count == '0);
      q_op  <= n_op;
      q_des <= n_des;
      q_s1  <= n_s1;
      q_s2  <= n_s2;
      q_ime <= n_ime;
      q_bid <= n_bid;
      for (int k = 0; k < ISSUE_W; k++) begin
        iq_out_vld[k] <= lane_fire[k];
        // Flushed picks still load their payload but are presented with vld=0.
        if (lane_used[k]) begin
          iq_out_op[k*OPW +: OPW]     <= q_op[sel_idx[k]];
          iq_out_des[k*REG_W +: REG_W] <= q_des[sel_idx[k]];
          iq_out_s1[k*REG_W +: REG_W]  <= q_s1[sel_idx[k]];
          iq_out_s2[k*REG_W +: REG_W]  <= q_s2[sel_idx[k]];
          iq_out_ime[k*IME_W +: IME_W] <= q_ime[sel_idx[k]];
          iq_out_bid[k*BID_W +: BID_W] <= q_bid[sel_idx[k]];
        end
      end
    end
  end

`ifdef ISSUE_QUEUE_PERF_CNT_EN
  logic [32:0] issue_sum;
  assign issue_sum = {1'b0, perf_issue_cnt} + 33'($countones(lane_fire));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cnt <= '0;
      perf_issue_cnt <= '0;
    end else begin
      if (|in_vld && !in_rdy && perf_stall_cnt != '1)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      perf_issue_cnt <= issue_sum[32] ? '1 : issue_sum[31:0];
    end
  end
`endif

endmodule
